// File: rtl/rob_flush_sequencer.sv
// ROB-side flush sequencer: tracks the oldest outstanding redirect, waits for
// it to reach the ROB head, then issues the reload pulse directly (after a
// drain delay) for BRU/LSU redirects. For CSR redirects it first holds stop
// until the CSR unit resumes, then issues the reload pulse.
//
// Ports:
//   Clk, Rest          clock (rising edge), async active-low reset
//   RedirectValid      single-cycle redirect notification
//   RedirectPtr        {wrap, index} of the redirecting instruction
//   RedirectIsCsr      1 = serialising CSR redirect
//   RobHeadPtr         {wrap, index} of the ROB head
//   RobHeadDone        head entry has completed
//   CsrResume          CSR unit finished the serialised operation
//   ROBReLoad          one-cycle reload pulse
//   ROBstop            frontend stop level during CSR serialisation
//   ReloadPtr          pointer of the redirect being retired (0 when idle)
//   Busy               sequencer is not idle
module rob_flush_sequencer #(
   parameter int unsigned PTRW         = 4,
   parameter int unsigned DRAIN_CYCLES = 2
) (
   input  logic            Clk,
   input  logic            Rest,
   input  logic            RedirectValid,
   input  logic [PTRW:0]   RedirectPtr,
   input  logic            RedirectIsCsr,
   input  logic [PTRW:0]   RobHeadPtr,
   input  logic            RobHeadDone,
   input  logic            CsrResume,
   output logic            ROBReLoad,
   output logic            ROBstop,
   output logic [PTRW:0]   ReloadPtr,
   output logic            Busy
);

   localparam int unsigned PW   = PTRW + 1;
   localparam int unsigned CNTW = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_HEAD,
      S_DRAIN,
      S_STOPPED,
      S_RELOAD
   } state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     pend_ptr_q, pend_ptr_d;
   logic              pend_csr_q, pend_csr_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              reload_q, reload_d;
   logic              stop_q, stop_d;
   logic              busy_q, busy_d;
   logic [PW-1:0]     rptr_q, rptr_d;
   logic              head_match;
   logic              redir_older;

   // a is older than b in ROB order; the wrap bit flips the index comparison
   function automatic logic is_older(input logic [PW-1:0] a, input logic [PW-1:0] b);
      if (a[PTRW] == b[PTRW]) begin
         return a[PTRW-1:0] < b[PTRW-1:0];
      end
      return a[PTRW-1:0] > b[PTRW-1:0];
   endfunction

   assign head_match  = (RobHeadPtr == pend_ptr_q) && RobHeadDone;
   assign redir_older = RedirectValid && is_older(RedirectPtr, pend_ptr_q);

   // State, pending redirect, drain counter and output registers
   always_ff @(posedge Clk or negedge Rest) begin
      if (!Rest) begin
         state_q    <= S_IDLE;
         pend_ptr_q <= '0;
         pend_csr_q <= 1'b0;
         cnt_q      <= '0;
         reload_q   <= 1'b0;
         stop_q     <= 1'b0;
         busy_q     <= 1'b0;
         rptr_q     <= '0;
      end else begin
         state_q    <= state_d;
         pend_ptr_q <= pend_ptr_d;
         pend_csr_q <= pend_csr_d;
         cnt_q      <= cnt_d;
         reload_q   <= reload_d;
         stop_q     <= stop_d;
         busy_q     <= busy_d;
         rptr_q     <= rptr_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      pend_ptr_d = pend_ptr_q;
      pend_csr_d = pend_csr_q;
      cnt_d      = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (RedirectValid) begin
               pend_ptr_d = RedirectPtr;
               pend_csr_d = RedirectIsCsr;
               state_d    = S_WAIT_HEAD;
            end
         end
         S_WAIT_HEAD: begin
            // An older redirect wins over a head match on the stale pointer
            if (redir_older) begin
               pend_ptr_d = RedirectPtr;
               pend_csr_d = RedirectIsCsr;
            end else if (head_match) begin
               if (pend_csr_q) begin
                  state_d = S_STOPPED;
               end else if (DRAIN_CYCLES == 0) begin
                  state_d = S_RELOAD;
               end else begin
                  cnt_d   = CNTW'(DRAIN_CYCLES - 1);
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (cnt_q == '0) begin
               state_d = S_RELOAD;
            end else begin
               cnt_d = cnt_q - CNTW'(1);
            end
         end
         S_STOPPED: begin
            if (CsrResume) begin
               state_d = S_RELOAD;
            end
         end
         S_RELOAD: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output next values, derived from the next state so outputs stay registered
   always_comb begin
      reload_d = (state_d == S_RELOAD);
      stop_d   = (state_d == S_STOPPED);
      busy_d   = (state_d != S_IDLE);
      rptr_d   = busy_d ? pend_ptr_d : '0;
   end

   assign ROBReLoad = reload_q;
   assign ROBstop   = stop_q;
   assign Busy      = busy_q;
   assign ReloadPtr = rptr_q;

endmodule
